whack_display: RTL and testbench

Output side of the whack-a-mole game. It consumes the mole position produced by the input/randomiser logic and the one-cycle hit/miss verdicts from the guess checker. It owns the mole lifetime timer, the hit/miss flash sequencing, a 4-digit BCD score and a lives counter. It drives the mole LEDs and a multiplexed 4-digit seven-segment display, and it requests the next mole from the input side.

---
 rtl/whack_pkg.sv | 67 ++++++
 rtl/whack_display_seg7_scan.sv | 52 +++++
 rtl/whack_display.sv | 149 ++++++++++++++
 tb/tb_whack_display.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/whack_pkg.sv
// Shared types, constants and helpers for the whack-a-mole display side.
package whack_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHOW,
    HIT_FLASH,
    MISS_FLASH,
    OVER
  } state_t;

  localparam int NUM_MOLES = 5;

  typedef logic [3:0] bcd_t;

  // Seven-segment patterns, active low, bit order {dp,g,f,e,d,c,b,a}
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Map one BCD digit to its segment pattern; non-decimal codes go blank
  function automatic logic [7:0] bcd_to_seg(input bcd_t d);
    logic [7:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Four-digit BCD increment that sticks at 9999 instead of wrapping
  function automatic logic [15:0] bcd_inc_sat(input logic [15:0] s);
    logic [15:0] r;
    logic        carry;
    r     = s;
    carry = (s != 16'h9999);
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/whack_display_seg7_scan.sv
// Multiplexed 4-digit seven-segment driver: scan counter, digit mux, decode.
module seg7_scan
  import whack_pkg::*;
#(
  parameter int SCAN_BITS = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] score,
  input  logic        dp_on,
  output logic [7:0]  seg,
  output logic [3:0]  an
);

  logic [SCAN_BITS-1:0] cnt;
  logic [1:0]           sel;
  bcd_t                 digit;
  logic [7:0]           seg_next;
  logic [3:0]           an_next;

  assign sel = cnt[SCAN_BITS-1 -: 2];

  // Pick the digit for the current scan slot and build its segment/anode pattern
  always_comb begin
    digit = score[3:0];
    case (sel)
      2'd0:    digit = score[3:0];
      2'd1:    digit = score[7:4];
      2'd2:    digit = score[11:8];
      default: digit = score[15:12];
    endcase
    seg_next = bcd_to_seg(digit);
    if ((sel == 2'd0) && dp_on) begin
      seg_next[7] = 1'b0;
    end
    an_next = ~(4'b0001 << sel);
  end

  // Free-running scan counter with registered display outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      seg <= SEG_BLANK;
      an  <= 4'b1111;
    end else begin
      cnt <= cnt + SCAN_BITS'(1);
      seg <= seg_next;
      an  <= an_next;
    end
  end

endmodule

// File: rtl/whack_display.sv
// Whack-a-mole output side: game FSM, mole/flash timer, BCD score, lives, display.
module whack_display
  import whack_pkg::*;
#(
  parameter int MOLE_CYCLES  = 150_000_000,
  parameter int FLASH_CYCLES = 25_000_000,
  parameter int SCAN_BITS    = 17,
  parameter int LIVES_INIT   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mole_valid,
  input  logic [2:0] mole_idx,
  input  logic       hit,
  input  logic       miss,
  output logic       new_mole_req,
  output logic       timeout,
  output logic [4:0] mole_led,
  output logic [2:0] lives_led,
  output logic       game_over,
  output logic [7:0] seg,
  output logic [3:0] an
);

  // One timer serves both the mole lifetime and the flash phase
  localparam int MAX_CYCLES = (MOLE_CYCLES > FLASH_CYCLES) ? MOLE_CYCLES : FLASH_CYCLES;
  localparam int TIMER_BITS = $clog2(MAX_CYCLES) + 1;
  localparam logic [TIMER_BITS-1:0] MOLE_LOAD  = TIMER_BITS'(MOLE_CYCLES - 1);
  localparam logic [TIMER_BITS-1:0] FLASH_LOAD = TIMER_BITS'(FLASH_CYCLES - 1);

  state_t                state, state_next;
  logic [2:0]            mole, mole_next;
  logic [TIMER_BITS-1:0] timer, timer_next;
  logic [15:0]           score, score_next;
  logic [2:0]            lives, lives_next;
  logic [4:0]            mole_led_next;
  logic                  req_next;
  logic                  timeout_next;

  // Next-state, datapath and output decode; outputs are derived from the next state so they register cleanly
  always_comb begin
    state_next    = state;
    mole_next     = mole;
    timer_next    = timer;
    score_next    = score;
    lives_next    = lives;
    req_next      = 1'b0;
    timeout_next  = 1'b0;
    mole_led_next = '0;

    case (state)
      IDLE: begin
        if (mole_valid && (mole_idx < 3'(NUM_MOLES))) begin
          mole_next  = mole_idx;
          timer_next = MOLE_LOAD;
          state_next = SHOW;
        end
      end
      SHOW: begin
        if (hit) begin
          score_next = bcd_inc_sat(score);
          timer_next = FLASH_LOAD;
          state_next = HIT_FLASH;
        end else if (miss) begin
          lives_next = (lives != 3'd0) ? lives - 3'd1 : lives;
          timer_next = FLASH_LOAD;
          state_next = MISS_FLASH;
        end else if (timer == '0) begin
          timeout_next = 1'b1;
          lives_next   = (lives != 3'd0) ? lives - 3'd1 : lives;
          timer_next   = FLASH_LOAD;
          state_next   = MISS_FLASH;
        end else begin
          timer_next = timer - 1'b1;
        end
      end
      HIT_FLASH: begin
        if (timer == '0) begin
          req_next   = 1'b1;
          state_next = IDLE;
        end else begin
          timer_next = timer - 1'b1;
        end
      end
      MISS_FLASH: begin
        if (timer == '0) begin
          if (lives == 3'd0) begin
            state_next = OVER;
          end else begin
            req_next   = 1'b1;
            state_next = IDLE;
          end
        end else begin
          timer_next = timer - 1'b1;
        end
      end
      OVER: begin
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    case (state_next)
      SHOW:      mole_led_next = 5'b00001 << mole_next;
      HIT_FLASH: mole_led_next = 5'b11111;
      default:   mole_led_next = '0;
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      mole         <= '0;
      timer        <= '0;
      score        <= '0;
      lives        <= 3'(LIVES_INIT);
      mole_led     <= '0;
      new_mole_req <= 1'b0;
      timeout      <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      state        <= state_next;
      mole         <= mole_next;
      timer        <= timer_next;
      score        <= score_next;
      lives        <= lives_next;
      mole_led     <= mole_led_next;
      new_mole_req <= req_next;
      timeout      <= timeout_next;
      game_over    <= (state_next == OVER);
    end
  end

  assign lives_led = lives;

  seg7_scan #(
    .SCAN_BITS(SCAN_BITS)
  ) u_scan (
    .clk  (clk),
    .rst  (rst),
    .score(score),
    .dp_on(game_over),
    .seg  (seg),
    .an   (an)
  );

endmodule

// File: tb/tb_whack_display.sv
// Scoreboard bench for whack_display with short timers and a fast display scan.
module tb_whack_display;

  localparam int MOLE_CYCLES  = 20;
  localparam int FLASH_CYCLES = 2;
  localparam int SCAN_BITS    = 4;
  localparam int LIVES_INIT   = 3;
  localparam int DWELL        = 1 << (SCAN_BITS - 2);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mole_valid = 1'b0;
  logic [2:0] mole_idx = 3'd0;
  logic       hit = 1'b0;
  logic       miss = 1'b0;
  logic       new_mole_req;
  logic       timeout;
  logic [4:0] mole_led;
  logic [2:0] lives_led;
  logic       game_over;
  logic [7:0] seg;
  logic [3:0] an;

  whack_display #(
    .MOLE_CYCLES (MOLE_CYCLES),
    .FLASH_CYCLES(FLASH_CYCLES),
    .SCAN_BITS   (SCAN_BITS),
    .LIVES_INIT  (LIVES_INIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mole_valid  (mole_valid),
    .mole_idx    (mole_idx),
    .hit         (hit),
    .miss        (miss),
    .new_mole_req(new_mole_req),
    .timeout     (timeout),
    .mole_led    (mole_led),
    .lives_led   (lives_led),
    .game_over   (game_over),
    .seg         (seg),
    .an          (an)
  );

  always #5 clk = ~clk;

  // Expected pulse events: either a timeout or a new_mole_req, with the cycle it must appear on
  typedef struct {
    bit         is_timeout;
    int         at_cyc;
    logic [2:0] lives;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   exp_score   = 0;
  int   lives_exp   = LIVES_INIT;

  // Cycle counter, advanced on every active edge
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every request/timeout pulse pops the scoreboard and is compared against it
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && (new_mole_req || timeout)) begin
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_pulse: req=%0b timeout=%0b at cycle %0d, no pulse expected",
                 new_mole_req, timeout, cyc);
      end else begin
        e = sb_q.pop_front();
        if ((timeout !== e.is_timeout) || (new_mole_req === e.is_timeout) ||
            (cyc != e.at_cyc) || (lives_led !== e.lives) || (mole_led !== 5'b00000)) begin
          miscompares++;
          $display("[TB] FAIL pulse: got timeout=%0b req=%0b cyc=%0d lives=%0d led=%b, expected timeout=%0b cyc=%0d lives=%0d led=00000",
                   timeout, new_mole_req, cyc, lives_led, mole_led, e.is_timeout, e.at_cyc, e.lives);
        end
      end
    end
  end

  // Hand-written segment table, active low {dp,g,f,e,d,c,b,a}
  function automatic logic [7:0] seg_of(input int d);
    case (d)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic int digit_of(input int value, input int pos);
    int v = value;
    for (int i = 0; i < pos; i++) v = v / 10;
    return v % 10;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs starting at a falling edge, then clear them
  task automatic applyStimulus(input logic mv, input logic [2:0] idx, input logic h, input logic m);
    mole_valid = mv;
    mole_idx   = idx;
    hit        = h;
    miss       = m;
    @(negedge clk);
    mole_valid = 1'b0;
    hit        = 1'b0;
    miss       = 1'b0;
  endtask

  // One mole: present it, then hit and/or miss on the next cycle, and wait out the flash
  task automatic play_mole(input logic [2:0] idx, input logic h, input logic m);
    applyStimulus(1'b1, idx, 1'b0, 1'b0);
    if (h) exp_score = (exp_score < 9999) ? exp_score + 1 : 9999;
    else if (m && lives_exp > 0) lives_exp--;
    if (h || lives_exp > 0) sb_q.push_back('{1'b0, cyc + 1 + FLASH_CYCLES, 3'(lives_exp)});
    applyStimulus(1'b0, 3'd0, h, m);
    repeat (FLASH_CYCLES) @(negedge clk);
  endtask

  // Wait (bounded) for a given digit slot and compare its segments
  task automatic check_digit(input int pos, input logic [7:0] exp_seg);
    logic [3:0] want;
    bit         found;
    want  = ~(4'b0001 << pos);
    found = 1'b0;
    for (int i = 0; i < 4 * DWELL + 2 && !found; i++) begin
      @(negedge clk);
      if (an === want) found = 1'b1;
    end
    checkOutput($sformatf("an_digit%0d", pos), {12'h0, an}, {12'h0, want});
    checkOutput($sformatf("seg_digit%0d", pos), {8'h0, seg}, {8'h0, exp_seg});
  endtask

  task automatic check_reset_state(input string tag);
    checkOutput({tag, "_mole_led"}, 16'(mole_led), 16'h0);
    checkOutput({tag, "_lives"}, 16'(lives_led), 16'(LIVES_INIT));
    checkOutput({tag, "_game_over"}, 16'(game_over), 16'h0);
    checkOutput({tag, "_req"}, 16'(new_mole_req), 16'h0);
    checkOutput({tag, "_timeout"}, 16'(timeout), 16'h0);
    checkOutput({tag, "_seg"}, 16'(seg), 16'h00FF);
    checkOutput({tag, "_an"}, 16'(an), 16'h000F);
  endtask

  initial begin : watchdog
    #(10 * 200_000);
    $display("[TB] FAIL watchdog: simulation exceeded its cycle budget");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [3:0] want_an;
    int         c0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    // Mole at index 2, hit ten cycles later
    applyStimulus(1'b1, 3'd2, 1'b0, 1'b0);
    checkOutput("show_idx2_led", 16'(mole_led), 16'h0004);
    repeat (9) @(negedge clk);
    exp_score = 1;
    sb_q.push_back('{1'b0, cyc + 1 + FLASH_CYCLES, 3'(lives_exp)});
    applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);
    checkOutput("hit_flash_led_first", 16'(mole_led), 16'h001F);
    @(negedge clk);
    checkOutput("hit_flash_led_last", 16'(mole_led), 16'h001F);
    @(negedge clk);
    checkOutput("after_flash_led", 16'(mole_led), 16'h0000);
    check_digit(0, seg_of(digit_of(exp_score, 0)));

    // Invalid mole index is ignored, as is a hit while idle
    applyStimulus(1'b1, 3'd6, 1'b0, 1'b0);
    checkOutput("invalid_idx_led", 16'(mole_led), 16'h0000);
    applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);
    repeat (MOLE_CYCLES + 5) @(negedge clk);
    checkOutput("invalid_idx_still_idle", 16'(mole_led), 16'h0000);

    // Let a mole time out
    c0 = cyc;
    lives_exp = 2;
    sb_q.push_back('{1'b1, c0 + 1 + MOLE_CYCLES, 3'd2});
    sb_q.push_back('{1'b0, c0 + 1 + MOLE_CYCLES + FLASH_CYCLES, 3'd2});
    applyStimulus(1'b1, 3'd0, 1'b0, 1'b0);
    checkOutput("show_idx0_led", 16'(mole_led), 16'h0001);
    repeat (MOLE_CYCLES + FLASH_CYCLES) @(negedge clk);
    checkOutput("timeout_lives", 16'(lives_led), 16'h0002);

    // Hit and miss together: hit wins
    play_mole(3'd4, 1'b1, 1'b1);
    checkOutput("hit_and_miss_lives", 16'(lives_led), 16'h0002);
    check_digit(0, seg_of(digit_of(exp_score, 0)));

    // Fresh game, three misses lead to game over
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    lives_exp = LIVES_INIT;
    exp_score = 0;
    play_mole(3'd1, 1'b0, 1'b1);
    play_mole(3'd3, 1'b0, 1'b1);
    applyStimulus(1'b1, 3'd2, 1'b0, 1'b0);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1);
    checkOutput("third_miss_lives", 16'(lives_led), 16'h0000);
    repeat (FLASH_CYCLES - 1) @(negedge clk);
    checkOutput("game_over_not_yet", 16'(game_over), 16'h0000);
    @(negedge clk);
    checkOutput("game_over_set", 16'(game_over), 16'h0001);
    applyStimulus(1'b1, 3'd1, 1'b0, 1'b0);
    checkOutput("over_ignores_mole", 16'(mole_led), 16'h0000);
    applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);
    repeat (MOLE_CYCLES + FLASH_CYCLES + 5) @(negedge clk);
    checkOutput("over_sticky", 16'(game_over), 16'h0001);
    checkOutput("over_lives", 16'(lives_led), 16'h0000);
    check_digit(0, seg_of(0) & 8'h7F);
    check_digit(1, seg_of(0));

    // Reset takes effect without waiting for a clock edge
    rst = 1'b1;
    #1;
    check_reset_state("async_reset");
    @(negedge clk);
    rst = 1'b0;
    lives_exp = LIVES_INIT;
    exp_score = 0;

    // Drive the score to 9999, then one more hit must saturate
    for (int i = 0; i < 10000; i++) begin
      play_mole(3'(i % 5), 1'b1, 1'b0);
    end

    // Align to the start of the ones-digit dwell, then walk all four digits
    for (int i = 0; i < 4 * DWELL + 2 && an !== 4'b0111; i++) @(negedge clk);
    for (int i = 0; i < DWELL + 2 && an !== 4'b1110; i++) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      want_an = ~(4'b0001 << k);
      checkOutput($sformatf("scan_an_%0d", k), 16'(an), 16'(want_an));
      checkOutput($sformatf("scan_seg_%0d", k), 16'(seg), 16'(seg_of(digit_of(exp_score, k))));
      repeat (DWELL) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_drained", 16'(sb_q.size()), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
